// File: rtl/mont_exp_sequencer.sv
// mont_exp_sequencer: left-to-right square-and-multiply controller for
// base^exp mod N, N = 2^64 - 15, driving an external free-running Montgomery
// multiplier. Domain entry is mont(base, R^2) and domain exit is mont(acc, 1).
// Optional build macro LEADING_ZERO_SKIP_EN: squares of leading zero exponent
// bits (where acc is still the Montgomery one) are skipped at one cycle per bit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a new request
// CONV_IN  | base_bar = mont(base, R2_MOD_N)
// SQUARE   | acc = mont(acc, acc) for exponent bit idx
// MULT     | acc = mont(acc, base_bar) because exponent bit idx is set
// CONV_OUT | result = mont(acc, 1)
// DONE     | result presented, waiting for res_ready
module mont_exp_sequencer #(
   parameter int          EXP_W       = 64,
   parameter int          MUL_LATENCY = 5,
   parameter logic [63:0] R_MOD_N     = 64'hF,
   parameter logic [63:0] R2_MOD_N    = 64'hE1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   output logic             ready_o,
   input  logic [63:0]      base_i,
   input  logic [EXP_W-1:0] exp_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [63:0]      result_o,
   output logic [63:0]      mul_a_bar_o,
   output logic [63:0]      mul_b_bar_o,
   input  logic [63:0]      mul_out_bar_i
);

   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam int CNT_W = (MUL_LATENCY > 0) ? $clog2(MUL_LATENCY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV_IN,
      S_SQUARE,
      S_MULT,
      S_CONV_OUT,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [EXP_W-1:0] exp_q;
   logic [63:0]      base_bar_q;
   logic [63:0]      acc_q;
   logic [63:0]      result_q;
   logic [63:0]      mul_a_q;
   logic [63:0]      mul_b_q;
   logic             ready_q;
   logic             res_valid_q;

   logic             last_d;
   logic             bit_d;
   logic             idx_zero_d;
   logic             skip_d;

   assign last_d     = (cnt_q == CNT_W'(MUL_LATENCY));
   assign bit_d      = exp_q[idx_q];
   assign idx_zero_d = (idx_q == '0);

`ifdef LEADING_ZERO_SKIP_EN
   // While every exponent bit from idx upward is zero, acc is still R mod N and
   // squaring it would return R mod N again, so the slot can be skipped.
   assign skip_d = (state_q == S_SQUARE) && ((exp_q >> idx_q) == '0);
`else
   assign skip_d = 1'b0;
`endif

   assign ready_o     = ready_q;
   assign res_valid_o = res_valid_q;
   assign result_o    = result_q;
   assign mul_a_bar_o = mul_a_q;
   assign mul_b_bar_o = mul_b_q;

   // Sequencer: operands are registered one slot ahead; the captured product is
   // forwarded straight into the next operand pair so no extra cycle is lost.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         exp_q       <= '0;
         base_bar_q  <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         ready_q     <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  exp_q   <= exp_i;
                  acc_q   <= R_MOD_N;
                  idx_q   <= IDX_W'(EXP_W - 1);
                  mul_a_q <= base_i;
                  mul_b_q <= R2_MOD_N;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= S_CONV_IN;
               end
            end
            S_CONV_IN: begin
               if (last_d) begin
                  base_bar_q <= mul_out_bar_i;
                  mul_a_q    <= acc_q;
                  mul_b_q    <= acc_q;
                  cnt_q      <= '0;
                  state_q    <= S_SQUARE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_SQUARE: begin
               if (skip_d) begin
                  if (idx_zero_d) begin
                     mul_a_q <= acc_q;
                     mul_b_q <= 64'd1;
                     state_q <= S_CONV_OUT;
                  end else begin
                     idx_q <= idx_q - IDX_W'(1);
                  end
               end else if (last_d) begin
                  acc_q   <= mul_out_bar_i;
                  mul_a_q <= mul_out_bar_i;
                  cnt_q   <= '0;
                  if (bit_d) begin
                     mul_b_q <= base_bar_q;
                     state_q <= S_MULT;
                  end else if (idx_zero_d) begin
                     mul_b_q <= 64'd1;
                     state_q <= S_CONV_OUT;
                  end else begin
                     mul_b_q <= mul_out_bar_i;
                     idx_q   <= idx_q - IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_MULT: begin
               if (last_d) begin
                  acc_q   <= mul_out_bar_i;
                  mul_a_q <= mul_out_bar_i;
                  cnt_q   <= '0;
                  if (idx_zero_d) begin
                     mul_b_q <= 64'd1;
                     state_q <= S_CONV_OUT;
                  end else begin
                     mul_b_q <= mul_out_bar_i;
                     idx_q   <= idx_q - IDX_W'(1);
                     state_q <= S_SQUARE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_CONV_OUT: begin
               if (last_d) begin
                  result_q    <= mul_out_bar_i;
                  res_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
